// File: rtl/cpu_clk_sched.sv
// Run/step/halt scheduler: divides I_CLK into the CPU clock O_CLK, gated by a mode FSM.
// Optional macro STEP_DEBOUNCE_EN adds a STEP_DEB-cycle debounce on the step button.
//
// state | meaning
// IDLE  | no CPU clock, waiting for run request or step edge
// RUN   | free-running divided clock
// STEP  | exactly one full O_CLK period, then back to IDLE
// HALT  | CPU halted, clock parked low until reset
module cpu_clk_sched #(
    parameter int DIV_W    = 32,
    parameter int DEF_HALF = 1000,
    parameter int STEP_DEB = 20000,
    parameter int CNT_W    = 32
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic             div_we,
    input  logic [DIV_W-1:0] div_val,
    output logic             O_CLK,
    output logic             O_CE,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] DEF_HALF_V = DIV_W'(DEF_HALF);

    state_t           state;
    state_t           state_nxt;
    logic             run_meta;
    logic             run_sync;
    logic             step_meta;
    logic             step_sync;
    logic             step_edge;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] half_act;
    logic [DIV_W-1:0] half_pend;
    logic [DIV_W-1:0] div_clean;
    logic [DIV_W-1:0] pend_nxt;
    logic             running;
    logic             toggle;
    logic             rise;
    logic             fall;
    logic             halt_pend;
    logic             halt_now;

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            run_meta  <= 1'b0;
            run_sync  <= 1'b0;
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            run_meta  <= run_i;
            run_sync  <= run_meta;
            step_meta <= step_i;
            step_sync <= step_meta;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int DEB_W = (STEP_DEB > 1) ? $clog2(STEP_DEB) : 1;
    localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(STEP_DEB - 1);

    logic [DEB_W-1:0] deb_cnt;
    logic             step_db;

    // Debounced level flips only after STEP_DEB consecutive cycles disagreeing with it.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            deb_cnt <= DEB_LOAD;
            step_db <= 1'b0;
        end else if (step_sync == step_db) begin
            deb_cnt <= DEB_LOAD;
        end else if (deb_cnt == '0) begin
            step_db <= step_sync;
            deb_cnt <= DEB_LOAD;
        end else begin
            deb_cnt <= deb_cnt - DEB_W'(1);
        end
    end

    assign step_edge = step_sync & ~step_db & (deb_cnt == '0);
`else
    logic step_prev;

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_sync;
        end
    end

    assign step_edge = step_sync & ~step_prev;
`endif

    assign running   = (state == S_RUN) || (state == S_STEP);
    assign toggle    = running && (div_cnt == (half_act - DIV_W'(1)));
    assign rise      = toggle & ~O_CLK;
    assign fall      = toggle & O_CLK;
    assign halt_now  = halt_i & O_CE;
    assign div_clean = (div_val == '0) ? DIV_W'(1) : div_val;
    // A write landing on a toggle is forwarded so it governs the half-period that starts there.
    assign pend_nxt  = div_we ? div_clean : half_pend;

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            half_act  <= DEF_HALF_V;
            half_pend <= DEF_HALF_V;
            O_CLK     <= 1'b0;
            O_CE      <= 1'b0;
            cyc_cnt   <= '0;
            halt_pend <= 1'b0;
        end else begin
            half_pend <= pend_nxt;
            if (!running || toggle) begin
                half_act <= pend_nxt;
                div_cnt  <= '0;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end
            if (toggle) begin
                O_CLK <= ~O_CLK;
            end
            O_CE <= rise;
            if (O_CE) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
            if (!running) begin
                halt_pend <= 1'b0;
            end else if (halt_now) begin
                halt_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving RUN/STEP only on a falling toggle guarantees no runt O_CLK pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (run_sync) begin
                    state_nxt = S_RUN;
                end else if (step_edge) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (fall && (halt_pend || halt_now)) begin
                    state_nxt = S_HALT;
                end else if (fall && !run_sync) begin
                    state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                if (fall) begin
                    state_nxt = (halt_pend || halt_now) ? S_HALT : S_IDLE;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        state_o = state;
    end

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Directed bench for cpu_clk_sched: divider table plus run/step/halt/reset sequences.
// Expectations for the short step press depend on STEP_DEBOUNCE_EN.
module tb_cpu_clk_sched;

    localparam int DIV_W = 32;
    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic             run_i;
    logic             step_i;
    logic             halt_i;
    logic             div_we;
    logic [DIV_W-1:0] div_val;
    logic             o_clk;
    logic             o_ce;
    logic [1:0]       state;
    logic [CNT_W-1:0] cyc;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [DIV_W-1:0] dv;
        int               old_half;
        int               new_half;
    } div_vec_t;

    div_vec_t tbl [3];

    cpu_clk_sched #(
        .DIV_W   (DIV_W),
        .DEF_HALF(4),
        .STEP_DEB(8),
        .CNT_W   (CNT_W)
    ) dut (
        .I_CLK  (clk),
        .rst    (rst),
        .run_i  (run_i),
        .step_i (step_i),
        .halt_i (halt_i),
        .div_we (div_we),
        .div_val(div_val),
        .O_CLK  (o_clk),
        .O_CE   (o_ce),
        .state_o(state),
        .cyc_cnt(cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic measure_run(input logic lvl, output int n);
        n = 0;
        while (o_clk === lvl && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int k = 0;
        while (state !== s && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, state, s);
    endtask

    task automatic wait_ce(input string name);
        int k = 0;
        while (o_ce !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, o_ce, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        int lo;
        int hi;
        int highs;
        int rises;
        int bad;
        int exp_short;
        logic prev;
        logic saw_step;
        logic [CNT_W-1:0] cyc0;

        tbl[0] = '{dv: 32'd2, old_half: 4, new_half: 2};
        tbl[1] = '{dv: 32'd3, old_half: 2, new_half: 3};
        tbl[2] = '{dv: 32'd0, old_half: 3, new_half: 1};

        rst = 1'b1; run_i = 1'b0; step_i = 1'b0; halt_i = 1'b0;
        div_we = 1'b0; div_val = '0;
        repeat (3) @(negedge clk);
        check("rst_o_clk", o_clk, 0);
        check("rst_o_ce", o_ce, 0);
        check("rst_state", state, 0);
        check("rst_cyc", cyc, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_state", state, 0);

        // Free run at the default half-period
        run_i = 1'b1;
        wait_state(2'b01, "t1_enter_run");
        measure_run(1'b0, n);
        check("t1_first_rise", n, 4);
        check("t1_ce_on_rise", o_ce, 1);
        @(negedge clk);
        check("t1_ce_width", o_ce, 0);
        measure_run(1'b1, n);
        check("t1_high_rest", n, 3);
        measure_run(1'b0, n);
        check("t1_low_half", n, 4);
        for (int i = 3; i <= 10; i++) begin
            @(negedge clk);
            wait_ce("t1_rise");
        end
        @(negedge clk);
        check("t1_cyc_10", cyc, 10);

        // Half-period rewrites while running
        for (int i = 0; i < 3; i++) begin
            wait_ce("t2_sync");
            div_val = tbl[i].dv;
            div_we  = 1'b1;
            @(negedge clk);
            div_we  = 1'b0;
            measure_run(1'b1, m);
            check($sformatf("t2_old_high_%0d", i), 1 + m, tbl[i].old_half);
            measure_run(1'b0, lo);
            check($sformatf("t2_new_low_%0d", i), lo, tbl[i].new_half);
            measure_run(1'b1, hi);
            check($sformatf("t2_new_high_%0d", i), hi, tbl[i].new_half);
        end

        // Asynchronous reset while O_CLK is high
        wait_ce("t6_high");
        #2 rst = 1'b1;
        #1;
        check("t6_o_clk", o_clk, 0);
        check("t6_o_ce", o_ce, 0);
        check("t6_state", state, 0);
        check("t6_cyc", cyc, 0);
        @(negedge clk);
        run_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_i = 1'b1;
        wait_state(2'b01, "t6_rerun");
        measure_run(1'b0, n);
        check("t6_default_rise", n, 4);
        measure_run(1'b1, n);
        check("t6_default_high", n, 4);

        // Dropping run while high finishes the period
        wait_ce("t4_high");
        run_i = 1'b0;
        measure_run(1'b1, n);
        check("t4_last_high", n, 4);
        check("t4_idle", state, 0);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_clk) highs++;
        end
        check("t4_stays_low", highs, 0);

        // Long step press: one full period
        cyc0 = cyc; highs = 0; rises = 0; prev = o_clk; saw_step = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step_i = (i < 20);
            @(negedge clk);
            if (o_clk) highs++;
            if (o_clk && !prev) rises++;
            prev = o_clk;
            if (state == 2'b10) saw_step = 1'b1;
        end
        check("t3_rises", rises, 1);
        check("t3_high_len", highs, 4);
        check("t3_cyc_inc", cyc - cyc0, 1);
        check("t3_back_idle", state, 0);
        check("t3_saw_step", saw_step, 1);

        // Short step press
`ifdef STEP_DEBOUNCE_EN
        exp_short = 0;
`else
        exp_short = 1;
`endif
        cyc0 = cyc; rises = 0; prev = o_clk;
        for (int i = 0; i < 30; i++) begin
            step_i = (i < 5);
            @(negedge clk);
            if (o_clk && !prev) rises++;
            prev = o_clk;
        end
        check("t3_short_rises", rises, exp_short);
        check("t3_short_cyc", cyc - cyc0, exp_short);
        check("t3_short_idle", state, 0);

        // Halt on an O_CE cycle
        run_i = 1'b1;
        wait_state(2'b01, "t5_run");
        wait_ce("t5_ce");
        halt_i = 1'b1;
        @(negedge clk);
        halt_i = 1'b0;
        check("t5_still_run", state, 1);
        measure_run(1'b1, m);
        check("t5_last_high", 1 + m, 4);
        check("t5_halt", state, 3);
        check("t5_o_clk_low", o_clk, 0);
        cyc0 = cyc;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            run_i  = ((i % 8) < 4);
            step_i = ((i % 16) < 12);
            @(negedge clk);
            if (state != 2'b11 || o_clk) bad++;
        end
        check("t5_held", bad, 0);
        check("t5_cyc_frozen", cyc - cyc0, 0);
        run_i = 1'b0; step_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_state", state, 0);
        check("t5_rst_cyc", cyc, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_clk_sched.md
Name: cpu_clk_sched

Overview:
Run/step/halt scheduler for the CPU clock in the static single-cycle CPU. It divides I_CLK down to O_CLK using a programmable half-period and gates it by a mode FSM (idle, free-run, single-step, halted). It also emits a one-cycle CPU clock-enable pulse and counts executed CPU cycles. It sits between the board clock/buttons and the CPU core.

Parameters:
DIV_W, 32, width of half-period register and divide counter
DEF_HALF, 1000, reset value of half-period, in I_CLK cycles
STEP_DEB, 20000, step-button debounce interval, in I_CLK cycles
CNT_W, 32, width of executed-cycle counter

Ports:
I_CLK  input  1  board clock
rst  input  1  asynchronous reset, active-high
run_i  input  1  level: 1 = free-run requested
step_i  input  1  raw step button, asynchronous to I_CLK
halt_i  input  1  CPU halt request, sampled on O_CE
div_we  input  1  write strobe for div_val
div_val  input  DIV_W  new half-period; 0 treated as 1
O_CLK  output  1  divided CPU clock
O_CE  output  1  one I_CLK pulse coincident with each O_CLK 0->1 edge
state_o  output  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT
cyc_cnt  output  CNT_W  number of O_CLK rising edges since reset, wraps

Behaviour:
- Reset is asynchronous, active-high, clock I_CLK. On reset: O_CLK=0, O_CE=0, state_o=IDLE, cyc_cnt=0, divide counter=0, active half=DEF_HALF, pending half=DEF_HALF, debounce/sync state cleared.
- Reset asserted mid-period aborts immediately. No further O_CLK edge until reset releases.
- Inputs run_i and step_i pass through 2-flop synchronizers, adding 2 cycles of latency.
- div_we captures div_val into the pending register. Pending is copied to active only when O_CLK toggles, or in IDLE/HALT immediately on the next cycle. A write therefore never shortens or stretches the half-period in progress. If div_we fires in the same cycle as a toggle, the new value applies to the next half-period.
- Divide counter runs only in RUN or STEP. It counts 0..active-1. When it reaches active-1: counter goes to 0 and O_CLK inverts. Counter is held at 0 in IDLE/HALT.
- O_CE=1 exactly in the I_CLK cycle after the toggle that drives O_CLK to 1, i.e. the cycle in which O_CLK first reads 1. Otherwise 0.
- cyc_cnt increments by 1 on each O_CE and wraps from all-ones to 0.
- FSM transitions are evaluated each I_CLK cycle:
  IDLE -> RUN when run_i_sync=1.
  IDLE -> STEP on a qualified step edge when run_i_sync=0.
  RUN -> IDLE when run_i_sync=0 and the 1->0 toggle of O_CLK occurs (finish the current period; no runt pulse).
  STEP -> IDLE at the first 1->0 toggle, so STEP yields exactly one full O_CLK period.
  RUN/STEP -> HALT when halt_i=1 in an O_CE cycle. The transition completes after the following 1->0 toggle, and state_o shows RUN/STEP until then.
  HALT is left only by rst.
- Step edges in RUN, STEP or HALT are discarded and not queued.
- Output O_CLK is always 0 in IDLE and HALT.
- First O_CLK rise after entering RUN/STEP occurs active cycles after entry.

Optional Feature:
Macro STEP_DEBOUNCE_EN.
- Defined: a qualified step edge requires step_i_sync to be stable 1 for STEP_DEB consecutive cycles after being 0. Release requires STEP_DEB stable-0 cycles before the next edge can qualify.
- Undefined: a qualified step edge is a plain 0->1 transition of step_i_sync, with no debounce counter.

Test Plan:
Bench parameters: DEF_HALF=4, STEP_DEB=8.
1. Release rst, then run_i=1 -> O_CLK period 8 I_CLK cycles; first rise 4 cycles after state_o=01; O_CE pulse width 1; cyc_cnt=10 after 10 rises.
2. In RUN, div_we with div_val=2 mid-half-period -> current half completes at 4 cycles; subsequent halves are 2 cycles; div_val=0 -> halves of 1 cycle.
3. In IDLE, step_i held high 20 cycles (debounce on) -> exactly one O_CLK high pulse of 4 cycles, cyc_cnt +1, state back to 00. Step held 5 cycles -> no pulse.
4. In RUN, drop run_i while O_CLK=1 -> O_CLK falls at the normal toggle, then stays 0; state_o=00; no pulse shorter than 4 cycles.
5. Assert halt_i on an O_CE -> one more falling toggle, then state_o=11 and O_CLK=0. run_i and step_i are then ignored until rst; rst returns state_o=00 and cyc_cnt=0.
6. Assert rst while O_CLK=1 in RUN -> O_CLK=0 and O_CE=0 immediately (asynchronous); counter and active half return to defaults.
